aes_cipher_core: RTL



---
 rtl/aes_cipher_core.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128 encryption, one full round per round key accepted from Key_Schedule.
// Optional feature macro AES_KEY_TIMEOUT_EN: abort with err_o when a round key is not delivered within TO_MAX cycles.
module aes_cipher_core #(
  parameter int NR     = 10,
  parameter int TO_MAX = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] plainText_i,
  output logic         keyEn_o,
  output logic [3:0]   selKey_o,
  input  logic [127:0] key_i,
  input  logic         keyRy_i,
  output logic [127:0] cipherText_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // FIPS-197 S-box; entry 0x00 occupies the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
    end
    return r;
  endfunction

  // Byte index is row + 4*column; row r rotates left by r columns.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127 - 8*(rw + 4*c) -: 8] = s[127 - 8*(rw + 4*((c + rw) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] aesState_q, aesState_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] cipher_q, cipher_d;
  logic [127:0] subShift, mixed, roundOut;
  logic         lastRound;

  assign lastRound = (rnd_q == 4'(NR));

  always_comb begin
    subShift = shiftRows(subBytes(aesState_q));
    mixed    = mixColumns(subShift);
    if (rnd_q == 4'd0) begin
      roundOut = aesState_q ^ key_i;
    end else if (lastRound) begin
      roundOut = subShift ^ key_i;
    end else begin
      roundOut = mixed ^ key_i;
    end
  end

`ifdef AES_KEY_TIMEOUT_EN
  logic [7:0] toCnt_q, toCnt_d;
  logic       err_q, err_d;
  logic       timeout;

  assign timeout = (toCnt_q == 8'(TO_MAX - 1));
`endif

  always_comb begin
    fsm_d      = fsm_q;
    aesState_d = aesState_q;
    rnd_d      = rnd_q;
    cipher_d   = cipher_q;
`ifdef AES_KEY_TIMEOUT_EN
    toCnt_d    = toCnt_q;
    err_d      = err_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d      = RUN;
          aesState_d = plainText_i;
          rnd_d      = 4'd0;
`ifdef AES_KEY_TIMEOUT_EN
          toCnt_d    = 8'd0;
          err_d      = 1'b0;
`endif
        end
      end
      RUN: begin
        if (keyRy_i) begin
          aesState_d = roundOut;
`ifdef AES_KEY_TIMEOUT_EN
          toCnt_d    = 8'd0;
`endif
          // Index returns to 0 after the final key so selKey_o idles at 0.
          if (lastRound) begin
            fsm_d    = DONE;
            cipher_d = roundOut;
            rnd_d    = 4'd0;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
`ifdef AES_KEY_TIMEOUT_EN
        else if (timeout) begin
          fsm_d = DONE;
          err_d = 1'b1;
        end else begin
          toCnt_d = toCnt_q + 8'd1;
        end
`endif
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q      <= IDLE;
      aesState_q <= '0;
      rnd_q      <= '0;
      cipher_q   <= '0;
    end else begin
      fsm_q      <= fsm_d;
      aesState_q <= aesState_d;
      rnd_q      <= rnd_d;
      cipher_q   <= cipher_d;
    end
  end

`ifdef AES_KEY_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toCnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      toCnt_q <= toCnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign keyEn_o      = (fsm_q == RUN);
  assign selKey_o     = rnd_q;
  assign cipherText_o = cipher_q;
  assign busy_o       = (fsm_q != IDLE);
  assign done_o       = (fsm_q == DONE);

endmodule
